// File: rtl/ser_tx_pkg.sv
// Shared types and line levels for the ser_tx serial frame transmitter.
package ser_tx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} ser_tx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/ser_tx_if.sv
// Word-side handshake and serial-side outputs of ser_tx, grouped as one bundle.
interface ser_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             dout;
    logic             busy;
    logic             done;

    modport master (output din, din_valid, input din_ready, dout, busy, done);
    modport slave  (input din, din_valid, output din_ready, dout, busy, done);
endinterface

// File: rtl/ser_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, tick marks the last count.
module ser_tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick,
    output logic tick_nxt_c
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;

    always_comb begin
        cnt_d = '0;
        if (run && !tick_q) cnt_d = cnt_q + CW'(1);
    end

    // tick_nxt_c lets the parent register a pulse that lines up with tick
    assign tick_nxt_c = (cnt_d == LAST);
    assign tick       = tick_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'(CLKS_PER_BIT == 1);
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_nxt_c;
        end
    end
endmodule

// File: rtl/ser_tx.sv
// Parallel-to-serial frame transmitter: start, data LSB-first, optional parity, stop.
// Define SER_TX_PARITY_EN to insert an even-parity bit between data and stop.
module ser_tx
    import ser_tx_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic     clk,
    input  logic     rst,
    ser_tx_if.slave  bus
);
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    ser_tx_state_e    state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             dout_q, dout_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             run_c, tick, tick_nxt_c;
`ifdef SER_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign run_c = (state_q != IDLE);

    ser_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (run_c),
        .tick       (tick),
        .tick_nxt_c (tick_nxt_c)
    );

    // Next-state and next-line-level; the line value is registered one cycle ahead
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bit_d    = bit_q;
        dout_d   = dout_q;
`ifdef SER_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.din_valid && rdy_q) begin
                    state_d  = START;
                    shreg_d  = WIDTH'(bus.din);
                    bit_d    = '0;
                    dout_d   = START_BIT;
`ifdef SER_TX_PARITY_EN
                    parity_d = ^bus.din;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    dout_d  = shreg_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
`ifdef SER_TX_PARITY_EN
                        state_d = PARITY;
                        dout_d  = parity_q;
`else
                        state_d = STOP;
                        dout_d  = STOP_BIT;
`endif
                    end else begin
                        shreg_d = shreg_q >> 1;
                        dout_d  = shreg_d[0];
                        bit_d   = bit_q + BW'(1);
                    end
                end
            end
`ifdef SER_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    dout_d  = STOP_BIT;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    dout_d  = LINE_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                dout_d  = LINE_IDLE;
            end
        endcase

        rdy_d  = (state_d == IDLE);
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && tick_nxt_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bit_q    <= '0;
            dout_q   <= LINE_IDLE;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SER_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bit_q    <= bit_d;
            dout_q   <= dout_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SER_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.din_ready = rdy_q;
    assign bus.dout      = dout_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
